// File: rtl/subtract_sequencer.sv
// subtract_sequencer: multi-cycle (4*NIBBLES)-bit subtractor a - b - bin.
// It drives an external combinational 4-bit subtractor one nibble per clock,
// least-significant nibble first. The borrow is chained through a register.
// Optional feature macro: SUBSEQ_OVERFLOW_EN adds the signed-overflow output o_ovf.
module subtract_sequencer #(
  parameter int unsigned NIBBLES = 4
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_start,
  input  logic [4*NIBBLES-1:0] i_a,
  input  logic [4*NIBBLES-1:0] i_b,
  input  logic                 i_bin,
  output logic                 o_busy,
  output logic                 o_done,
  output logic [4*NIBBLES-1:0] o_d,
  output logic                 o_bout,
`ifdef SUBSEQ_OVERFLOW_EN
  output logic                 o_ovf,
`endif
  output logic [3:0]           o_sub_a,
  output logic [3:0]           o_sub_b,
  output logic                 o_sub_bin,
  input  logic [3:0]           i_sub_d,
  input  logic                 i_sub_bout
);

  localparam int unsigned W    = 4 * NIBBLES;
  localparam int unsigned CntW = 4;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e            r_state;
  state_e            w_state_next;
  logic [W-1:0]      r_a_sh;
  logic [W-1:0]      r_b_sh;
  logic              r_borrow;
  logic [CntW-1:0]   r_cnt;
  logic [W-1:0]      r_res;
  logic [W-1:0]      r_d;
  logic              r_bout;
  logic              w_run;
  logic              w_accept;
  logic              w_last;
  logic [W-1:0]      w_res_next;
`ifdef SUBSEQ_OVERFLOW_EN
  logic              r_sign_a;
  logic              r_sign_b;
  logic              r_ovf;
`endif

  assign w_run      = (r_state == StRun);
  // start is only honoured outside RUN, so an operation in flight is never disturbed
  assign w_accept   = (r_state != StRun) && i_start;
  assign w_last     = w_run && (r_cnt == CntW'(NIBBLES - 1));
  // New nibble enters at the top; after NIBBLES captures nibble 0 has reached the bottom
  assign w_res_next = (r_res >> 4) | (W'(i_sub_d) << (W - 4));

  // State register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle:  w_state_next = i_start ? StRun : StIdle;
      StRun:   w_state_next = (r_cnt == CntW'(NIBBLES - 1)) ? StDone : StRun;
      StDone:  w_state_next = i_start ? StRun : StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  // Outputs decoded from state; subtractor inputs are forced to 0 outside RUN
  always_comb begin
    o_busy    = w_run;
    o_done    = (r_state == StDone);
    o_sub_a   = w_run ? r_a_sh[3:0] : 4'd0;
    o_sub_b   = w_run ? r_b_sh[3:0] : 4'd0;
    o_sub_bin = w_run ? r_borrow : 1'b0;
  end

  // Datapath: operand shifting, borrow chaining, result collection
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_a_sh   <= '0;
      r_b_sh   <= '0;
      r_borrow <= 1'b0;
      r_cnt    <= '0;
      r_res    <= '0;
      r_d      <= '0;
      r_bout   <= 1'b0;
`ifdef SUBSEQ_OVERFLOW_EN
      r_sign_a <= 1'b0;
      r_sign_b <= 1'b0;
      r_ovf    <= 1'b0;
`endif
    end else if (w_accept) begin
      r_a_sh   <= i_a;
      r_b_sh   <= i_b;
      r_borrow <= i_bin;
      r_cnt    <= '0;
      r_res    <= '0;
`ifdef SUBSEQ_OVERFLOW_EN
      // Operand signs are shifted out during RUN, so keep them aside
      r_sign_a <= i_a[W-1];
      r_sign_b <= i_b[W-1];
`endif
    end else if (w_run) begin
      r_res    <= w_res_next;
      r_borrow <= i_sub_bout;
      r_a_sh   <= r_a_sh >> 4;
      r_b_sh   <= r_b_sh >> 4;
      r_cnt    <= r_cnt + CntW'(1);
      if (w_last) begin
        r_d    <= w_res_next;
        r_bout <= i_sub_bout;
`ifdef SUBSEQ_OVERFLOW_EN
        r_ovf  <= (r_sign_a ^ r_sign_b) & (r_sign_a ^ w_res_next[W-1]);
`endif
      end
    end
  end

  assign o_d    = r_d;
  assign o_bout = r_bout;
`ifdef SUBSEQ_OVERFLOW_EN
  assign o_ovf  = r_ovf;
`endif

endmodule

// File: doc/subtract_sequencer.md
# subtract_sequencer

Multi-cycle sequencer that performs a (4·NIBBLES)-bit subtraction a − b − bin using the team's 4-bit parallel subtractor as its datapath. On `start` it latches both operands. It then feeds them one nibble per clock, least-significant nibble first, to the external subtractor and chains the borrow through a register. It collects each 4-bit difference and reports the full-width result with a one-cycle `done` strobe. It sits directly in front of and behind the 4-bit subtractor, driving its `a/b/bin` inputs and consuming its `d/bout` outputs.

## Interface
- NIBBLES, default 4: number of 4-bit slices; operand width W = 4·NIBBLES; legal range 1..8.
- clk  in  1  rising-edge clock, the only clock.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  request; sampled only when not busy.
- a  in  W  minuend; sampled with start.
- b  in  W  subtrahend; sampled with start.
- bin  in  1  initial borrow-in; sampled with start.
- busy  out  1  high while nibbles are being processed.
- done  out  1  one-cycle strobe; d/bout valid.
- d  out  W  difference a − b − bin, mod 2^W.
- bout  out  1  final borrow-out (1 when a < b + bin, unsigned).
- sub_a  out  4  nibble to subtractor input a.
- sub_b  out  4  nibble to subtractor input b.
- sub_bin  out  1  borrow to subtractor input bin.
- sub_d  in  4  difference from subtractor.
- sub_bout  in  1  borrow-out from subtractor.
- ovf  out  1  signed overflow; present only with SUBSEQ_OVERFLOW_EN.

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE/DONE + start=1: load a and b into shift registers, load the borrow register with bin, clear the nibble counter, and go to RUN.
- IDLE/DONE + start=0: stay in IDLE; DONE always moves to IDLE after one cycle.
- RUN:
  - sub_a and sub_b are the low nibbles of the operand shift registers; sub_bin is the borrow register.
  - Each edge: shift sub_d into the top of the result register, shifting the result right by 4; load the borrow register with sub_bout; shift the operands right by 4; increment the counter.
  - After the NIBBLES-th capture, go to DONE.
- The subtractor is combinational. sub_d and sub_bout must settle within one clock of a change on sub_a, sub_b or sub_bin.
- Outside RUN, sub_a, sub_b and sub_bin are driven 0.
- d and bout update only on the final capture and hold until the next operation completes.
- start while busy is ignored; the operation in flight completes unchanged.

## Timing
- Reset (asynchronous, immediate): state IDLE; busy=0, done=0, d=0, bout=0, ovf=0, sub_a=0, sub_b=0, sub_bin=0; counter and shift registers cleared.
- Start accepted at edge E0:
  - busy is high from E0 to E_NIBBLES.
  - Nibble k is presented during the cycle after E_k and captured at E_(k+1).
  - done, together with the new d and bout, is high for exactly one cycle after E_NIBBLES.
- Latency: NIBBLES edges from the start edge to done. Throughput: one operation per NIBBLES+1 cycles when start is held high, since start is accepted in DONE.
- rst_n asserted mid-RUN: abort at once, with no done pulse. After rst_n deasserts, the next start behaves normally.

## Configuration
- SUBSEQ_OVERFLOW_EN defined:
  - The ovf port exists.
  - At the final capture, ovf = (a[W−1] ^ b[W−1]) & (a[W−1] ^ d[W−1]), using the latched operand signs and the final result.
  - ovf updates and holds like d.
- Not defined: the ovf port and its logic are absent, and all other behaviour is identical.

## Test plan
- a=0x1234, b=0x0123, bin=0 -> d=0x1111, bout=0. done is one cycle wide, 4 edges after start. sub_* show nibbles 4/3, 3/2, 2/1, 1/0 in order.
- a=0x0000, b=0x0001, bin=0 -> d=0xFFFF, bout=1. The borrow register is 1 after every nibble.
- a=0x0005, b=0x0005, bin=1 -> d=0xFFFF, bout=1. a=0x8000, b=0x0001 -> d=0x7FFF, bout=0, ovf=1 (with macro).
- Start with a=0x00FF, b=0x000F; pulse start with a=0xFFFF, b=0 at edges E1 and E2 -> ignored; d=0x00F0. Start held high -> back-to-back results every 5 cycles.
- rst_n low during the 2nd nibble -> all outputs 0 immediately and no done. Then a=0x0010, b=0x0001 -> d=0x000F.
- Exhaustive check with NIBBLES=1: all 512 combinations of a, b, bin -> d and bout match a 4-bit reference subtraction.
